write_back_buffer: RTL

WRITE_BACK_BUFFER -- requirements
Module: write_back_buffer

---
 rtl/write_back_buffer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/write_back_buffer.sv
// Purpose : 4-entry in-order write-back buffer in front of a register file write port,
//           with combinational bypass lookups over the pending (not yet written) entries.
// Latency : an accepted write is presented on the write port the cycle after acceptance at
//           the earliest; bypass lookups are combinational.
// Backpr. : inReady drops while 4 entries are pending (registered count only, no push-through);
//           the write port is held until rfReady consumes it.
//
// Ports
//   clock, reset           single clock, asynchronous active-low reset
//   inValid/inReady        producer handshake for {inRegister, inData}
//   regWrite/rfReady       register file write strobe and its consume handshake
//   writeRegister/Data     head entry, zero when empty
//   lookupRegister1/2      decode read-port register numbers
//   bypassHit1/2, Data1/2  youngest pending match per lookup port, zero when no hit
//   count                  number of pending entries (0..4)
module write_back_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inValid,
    input  logic [4:0]  inRegister,
    input  logic [31:0] inData,
    output logic        inReady,
    output logic        regWrite,
    output logic [4:0]  writeRegister,
    output logic [31:0] writeData,
    input  logic        rfReady,
    input  logic [4:0]  lookupRegister1,
    input  logic [4:0]  lookupRegister2,
    output logic        bypassHit1,
    output logic        bypassHit2,
    output logic [31:0] bypassData1,
    output logic [31:0] bypassData2,
    output logic [2:0]  count
);

    localparam int PTR_W = 2;
    localparam int CNT_W = 3;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] dat;
    } wb_ent_t;

    wb_ent_t            ent_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               accept;
    logic               push;
    logic               pop;

    // Handshake and write port.
    // Full is judged from the registered count only, so a pop in the same cycle
    // never opens a slot for the incoming write.
    assign inReady = (count_q != CNT_W'(DEPTH));
    assign accept  = inValid && inReady;
    // Writes to r0 complete the handshake but are dropped: r0 is hardwired zero.
    assign push    = accept && (inRegister != 5'd0);

    assign regWrite      = (count_q != '0);
    assign pop           = regWrite && rfReady;
    // Popped slots keep stale contents, so the port is gated to zero when empty.
    assign writeRegister = regWrite ? ent_q[head_q].rd  : 5'd0;
    assign writeData     = regWrite ? ent_q[head_q].dat : 32'd0;
    assign count         = count_q;

    // Next-state pointers and occupancy.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Bypass lookup.
    // Walk the valid entries oldest to youngest, letting later matches override
    // earlier ones so the most recently accepted write wins. Only registered
    // entries are scanned, so the write being accepted this cycle is invisible,
    // while the head being popped this cycle is still visible.
    logic [PTR_W-1:0] slot;

    always_comb begin
        slot        = '0;
        bypassHit1  = 1'b0;
        bypassHit2  = 1'b0;
        bypassData1 = 32'd0;
        bypassData2 = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if ((lookupRegister1 != 5'd0) && (ent_q[slot].rd == lookupRegister1)) begin
                    bypassHit1  = 1'b1;
                    bypassData1 = ent_q[slot].dat;
                end
                if ((lookupRegister2 != 5'd0) && (ent_q[slot].rd == lookupRegister2)) begin
                    bypassHit2  = 1'b1;
                    bypassData2 = ent_q[slot].dat;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                ent_q[tail_q] <= '{rd: inRegister, dat: inData};
            end
        end
    end

endmodule
